// File: rtl/pong_pkg.sv
// Types and constants shared across the pong scoring blocks.
// Holds the scoring FSM state type, the BCD digit width and a helper that turns an integer into packed BCD.
package pong_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_SERVE = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  // Packs up to eight decimal digits, digit 0 in the LSBs.
  function automatic logic [31:0] int_to_bcd(input int unsigned value);
    logic [31:0] packed_bcd;
    int unsigned rest;
    packed_bcd = '0;
    rest       = value;
    for (int i = 0; i < 8; i++) begin
      packed_bcd[i*BCD_W +: BCD_W] = BCD_W'(rest % 10);
      rest                         = rest / 10;
    end
    return packed_bcd;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter.sv
// Multi-digit packed-BCD counter with ripple carry; it holds at all nines instead of wrapping.
// inc_value is the value the counter would load on inc, which lets the parent look ahead for a win.
module bcd_counter
  import pong_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic [BCD_W*DIGITS-1:0] inc_value
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]    count_q;
  logic [W-1:0]    bumped;
  logic [DIGITS:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] digit;
      assign digit         = count_q[gi*BCD_W +: BCD_W];
      assign carry[gi + 1] = carry[gi] & (digit == BCD_W'(9));
      assign bumped[gi*BCD_W +: BCD_W] = !carry[gi]          ? digit :
                                         (digit == BCD_W'(9)) ? '0    :
                                                                digit + BCD_W'(1);
    end
  endgenerate

  // A carry out of the top digit means every digit is 9: saturate.
  assign inc_value = carry[DIGITS] ? count_q : bumped;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= inc_value;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: detects the ball leaving either side on frame ticks, awards points,
// holds a serve delay between points and stops the game once a player reaches the winning score.
module score_keeper
  import pong_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int BW_W         = 6,
  parameter int SCREEN_W     = 640,
  parameter int DIGITS       = 4,
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [X_W-1:0]          ball_x,
  input  logic [BW_W-1:0]         ball_width,
  input  logic                    new_game,
  output logic [BCD_W*DIGITS-1:0] score_l,
  output logic [BCD_W*DIGITS-1:0] score_r,
  output logic                    point_l,
  output logic                    point_r,
  output logic                    serve_pending,
  output logic                    game_over,
  output logic                    winner
);

  localparam int SCORE_W = BCD_W * DIGITS;
  localparam int SUM_W   = X_W + 1;
  localparam int CNT_W   = (SERVE_FRAMES == 0) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SERVE_FRAMES == 0) ? 0 : SERVE_FRAMES - 1);
  localparam logic [31:0] SCREEN_LIM = 32'(SCREEN_W);
  // A winning score the counters cannot represent would alias after BCD truncation, so it is disabled.
  localparam bit WIN_EN = (WIN_SCORE != 0) && (WIN_SCORE <= (10 ** DIGITS) - 1);
  localparam logic [31:0] WIN_BCD32 = int_to_bcd(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_BCD = WIN_BCD32[SCORE_W-1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             point_l_q, point_l_d;
  logic             point_r_q, point_r_d;
  logic             winner_q, winner_d;
  logic             inc_l, inc_r, clr_scores;
  logic [SUM_W-1:0] right_sum;
  logic             right_exit, left_exit;
  logic [SCORE_W-1:0] next_l, next_r;

  assign right_sum  = SUM_W'(ball_x) + SUM_W'(ball_width);
  assign right_exit = 32'(right_sum) >= SCREEN_LIM;
  assign left_exit  = (ball_x == '0);

  bcd_counter #(.DIGITS(DIGITS)) u_score_l (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc_l),
    .clr      (clr_scores),
    .count    (score_l),
    .inc_value(next_l)
  );

  bcd_counter #(.DIGITS(DIGITS)) u_score_r (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc_r),
    .clr      (clr_scores),
    .count    (score_r),
    .inc_value(next_r)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    point_l_d  = 1'b0;
    point_r_d  = 1'b0;
    winner_d   = winner_q;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    clr_scores = 1'b0;

    if (new_game) begin
      state_d    = ST_PLAY;
      cnt_d      = '0;
      winner_d   = 1'b0;
      clr_scores = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          // Both edges touched at once is ambiguous, so nobody scores.
          if (frame_tick && (right_exit != left_exit)) begin
            cnt_d = '0;
            if (right_exit) begin
              inc_l     = 1'b1;
              point_l_d = 1'b1;
              if (WIN_EN && (next_l == WIN_BCD)) begin
                state_d  = ST_OVER;
                winner_d = 1'b0;
              end else begin
                state_d = ST_SERVE;
              end
            end else begin
              inc_r     = 1'b1;
              point_r_d = 1'b1;
              if (WIN_EN && (next_r == WIN_BCD)) begin
                state_d  = ST_OVER;
                winner_d = 1'b1;
              end else begin
                state_d = ST_SERVE;
              end
            end
          end
        end
        ST_SERVE: begin
          if (SERVE_FRAMES == 0) begin
            state_d = ST_PLAY;
          end else if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PLAY;
      cnt_q     <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      winner_q  <= winner_d;
    end
  end

  assign point_l       = point_l_q;
  assign point_r       = point_r_q;
  assign winner        = winner_q;
  assign serve_pending = (state_q == ST_SERVE);
  assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (default game and a small saturating one) driven by
// shared stimulus and checked every cycle against a decimal-arithmetic model, plus literal checks.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       new_game = 1'b0;
  logic [9:0] ball_x = '0;
  logic [5:0] ball_width = '0;

  logic [15:0] a_sl, a_sr;
  logic [7:0]  b_sl, b_sr;
  logic        a_pl, a_pr, a_sp, a_go, a_w;
  logic        b_pl, b_pr, b_sp, b_go, b_w;

  always #5 clk = ~clk;

  score_keeper #(.X_W(10), .BW_W(6), .SCREEN_W(640), .DIGITS(4), .WIN_SCORE(11), .SERVE_FRAMES(60)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ball_x(ball_x), .ball_width(ball_width),
    .new_game(new_game), .score_l(a_sl), .score_r(a_sr), .point_l(a_pl), .point_r(a_pr),
    .serve_pending(a_sp), .game_over(a_go), .winner(a_w)
  );

  score_keeper #(.X_W(10), .BW_W(6), .SCREEN_W(32), .DIGITS(2), .WIN_SCORE(0), .SERVE_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ball_x(ball_x), .ball_width(ball_width),
    .new_game(new_game), .score_l(b_sl), .score_r(b_sr), .point_l(b_pl), .point_r(b_pr),
    .serve_pending(b_sp), .game_over(b_go), .winner(b_w)
  );

  int n_pass = 0;
  int n_total = 0;
  int pr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Model: mode 0 = playing, 1 = waiting to serve, 2 = game finished.
  int p_sw[2]  = '{640, 32};
  int p_max[2] = '{9999, 99};
  int p_win[2] = '{11, 0};
  int p_sf[2]  = '{60, 0};
  int m_mode[2], m_sl[2], m_sr[2], m_rem[2];
  bit m_pl[2], m_pr[2], m_w[2];

  bit s_reset, s_new, s_tick;
  int s_x, s_w;
  always @(posedge clk) begin
    s_reset <= reset;
    s_new   <= new_game;
    s_tick  <= frame_tick;
    s_x     <= int'(ball_x);
    s_w     <= int'(ball_width);
  end

  task automatic model_step();
    bit re, le, side;
    int total;
    for (int i = 0; i < 2; i++) begin
      m_pl[i] = 1'b0;
      m_pr[i] = 1'b0;
      if (s_reset || s_new) begin
        m_mode[i] = 0; m_sl[i] = 0; m_sr[i] = 0; m_w[i] = 1'b0; m_rem[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (s_tick) begin
          re = (s_x + s_w) >= p_sw[i];
          le = (s_x == 0);
          if (re != le) begin
            if (re) begin
              if (m_sl[i] < p_max[i]) m_sl[i]++;
              m_pl[i] = 1'b1; side = 1'b0; total = m_sl[i];
            end else begin
              if (m_sr[i] < p_max[i]) m_sr[i]++;
              m_pr[i] = 1'b1; side = 1'b1; total = m_sr[i];
            end
            if (p_win[i] != 0 && total == p_win[i]) begin
              m_mode[i] = 2; m_w[i] = side;
            end else begin
              m_mode[i] = 1; m_rem[i] = p_sf[i];
            end
          end
        end
      end else if (m_mode[i] == 1) begin
        if (p_sf[i] == 0) m_mode[i] = 0;
        else if (s_tick) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_mode[i] = 0;
        end
      end
    end
  endtask

  task automatic cmp_dut(input int i, input string tag, input logic [31:0] sl, input logic [31:0] sr,
                         input logic pl, input logic pr, input logic sp, input logic go, input logic w);
    chk({tag, ".score_l"}, sl, to_bcd(m_sl[i]));
    chk({tag, ".score_r"}, sr, to_bcd(m_sr[i]));
    chk({tag, ".point_l"}, 32'(pl), 32'(m_pl[i]));
    chk({tag, ".point_r"}, 32'(pr), 32'(m_pr[i]));
    chk({tag, ".serve_pending"}, 32'(sp), 32'(m_mode[i] == 1));
    chk({tag, ".game_over"}, 32'(go), 32'(m_mode[i] == 2));
    chk({tag, ".winner"}, 32'(w), 32'(m_w[i]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      cmp_dut(0, "a", 32'(a_sl), 32'(a_sr), a_pl, a_pr, a_sp, a_go, a_w);
      cmp_dut(1, "b", 32'(b_sl), 32'(b_sr), b_pl, b_pr, b_sp, b_go, b_w);
      if (a_pr) pr_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int x, input int w);
    frame_tick = 1'b1;
    ball_x     = 10'(x);
    ball_width = 6'(w);
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (3) cyc();
    chk("reset.score_l", 32'(a_sl), 32'h0);
    chk("reset.serve", 32'({a_sp, a_go, a_w, a_pl, a_pr}), 32'h0);
    reset = 1'b0;
    cyc();

    // Right exit exactly at the screen edge.
    frame(620, 20);
    chk("exit_r.point_l", 32'(a_pl), 32'h1);
    chk("exit_r.score_l", 32'(a_sl), 32'h0001);
    chk("exit_r.serve", 32'(a_sp), 32'h1);
    cyc();
    chk("exit_r.pulse_once", 32'(a_pl), 32'h0);

    // Ball parked on the left edge for 100 frames.
    start_game();
    pr_cnt = 0;
    for (int f = 1; f <= 100; f++) begin
      frame(0, 5);
      if (f == 9)  chk("b.score_r_09", 32'(b_sr), 32'h09);
      if (f == 10) chk("b.score_r_10", 32'(b_sr), 32'h10);
      cyc();
    end
    chk("hold.score_r", 32'(a_sr), 32'h0002);
    chk("hold.pulses", 32'(pr_cnt), 32'd2);
    chk("b.saturate", 32'(b_sr), 32'h99);

    // Both edges true only on the small screen.
    start_game();
    frame(0, 40);
    chk("both.b_points", 32'({b_pl, b_pr}), 32'h0);
    chk("both.b_serve", 32'(b_sp), 32'h0);
    chk("both.a_point_r", 32'(a_pr), 32'h1);

    // Play to the winning score on the right side.
    start_game();
    frame_tick = 1'b1;
    ball_x = '0;
    ball_width = 6'd3;
    guard = 0;
    while (!a_go && guard < 2000) begin
      cyc();
      guard++;
    end
    frame_tick = 1'b0;
    chk("win.game_over", 32'(a_go), 32'h1);
    chk("win.score_r", 32'(a_sr), 32'h0011);
    chk("win.winner", 32'(a_w), 32'h1);
    for (int k = 0; k < 40; k++) frame((k % 2 == 0) ? 0 : 620, 20);
    chk("over.score_r", 32'(a_sr), 32'h0011);
    chk("over.score_l", 32'(a_sl), 32'h0);
    chk("over.hold", 32'(a_go), 32'h1);
    start_game();
    chk("newgame.scores", 32'({a_sl, a_sr}), 32'h0);
    chk("newgame.state", 32'({a_go, a_sp, a_w}), 32'h0);

    // Reset mid-serve, coinciding with an exit tick.
    frame(620, 20);
    reset = 1'b1;
    frame(620, 20);
    reset = 1'b0;
    chk("rst.score_l", 32'(a_sl), 32'h0);
    chk("rst.flags", 32'({a_pl, a_pr, a_sp, a_go, a_w}), 32'h0);
    chk("rst.b_score_l", 32'(b_sl), 32'h0);

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      frame_tick = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ball_x = '0;
        1:       ball_x = 10'($urandom_range(580, 1023));
        2:       ball_x = 10'($urandom);
        default: ball_x = 10'($urandom_range(0, 40));
      endcase
      ball_width = 6'($urandom_range(0, 63));
      new_game   = ($urandom_range(0, 199) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      cyc();
    end
    frame_tick = 1'b0;
    new_game = 1'b0;
    reset = 1'b0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter X_W, 10, width of ball_x.
REQ-002 Parameter BW_W, 6, width of ball_width.
REQ-003 Parameter SCREEN_W, 640, playfield width in pixels.
REQ-004 Parameter DIGITS, 4, BCD digits per score (max 10^DIGITS-1).
REQ-005 Parameter WIN_SCORE, 11, points that end a game; 0 disables game-over.
REQ-006 Parameter SERVE_FRAMES, 60, frames held in SERVE after a point.
REQ-007 clk  in  1  single system clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame; the only cycle on which the ball is sampled.
REQ-010 ball_x  in  X_W  ball left-edge x coordinate.
REQ-011 ball_width  in  BW_W  ball width in pixels.
REQ-012 new_game  in  1  one-cycle request to clear scores and restart.
REQ-013 score_l  out  4*DIGITS  left player score, packed BCD, digit 0 in LSBs.
REQ-014 score_r  out  4*DIGITS  right player score, packed BCD.
REQ-015 point_l, point_r  out  1 each  one-cycle pulse when that player scores.
REQ-016 serve_pending  out  1  high while in SERVE.
REQ-017 game_over  out  1  high while in OVER.
REQ-018 winner  out  1  0 = left, 1 = right; valid while game_over.

Function
REQ-019 FSM states PLAY, SERVE and OVER shall exist; after reset the state shall be PLAY.
REQ-020 The right-exit condition shall be ball_x + ball_width >= SCREEN_W, evaluated at X_W+1 bits with no truncation; it shall award a point to the left player.
REQ-021 The left-exit condition shall be ball_x == 0; it shall award a point to the right player.
REQ-022 Exit conditions shall be evaluated only in PLAY on a frame_tick cycle; at all other times they shall be ignored.
REQ-023 If both exit conditions are true on the same evaluated tick, no point shall be awarded and the state shall remain PLAY.
REQ-024 A point shall be awarded at most once per exit: after awarding it, the FSM shall enter SERVE, and it shall not return to PLAY until SERVE_FRAMES frame_ticks have elapsed.
REQ-025 The score register, the point pulse and the state change shall all update on the clock edge that samples frame_tick, so they are visible the following cycle (latency 1).
REQ-026 The score shall increment in BCD with a ripple carry across digits and shall saturate at all-9s without wrapping.
REQ-027 If WIN_SCORE is nonzero and the incremented score equals WIN_SCORE, the FSM shall enter OVER instead of SERVE, with winner set to the scoring side; the point pulse shall still fire.
REQ-028 OVER shall hold the scores and winner until new_game is asserted.
REQ-029 A new_game pulse in any state shall clear both scores and winner and shall load PLAY on the next edge; new_game shall take priority over a concurrent exit.
REQ-030 If SERVE_FRAMES = 0, SERVE shall last exactly one cycle.
REQ-031 The SERVE frame counter shall be sized as $clog2(SERVE_FRAMES+1) bits.

Reset
REQ-032 Reset shall set state to PLAY, score_l and score_r to 0, point_l and point_r to 0, serve_pending to 0, game_over to 0, winner to 0, and the frame counter to 0.
REQ-033 Reset shall override frame_tick and new_game on the same edge, and reset asserted mid-SERVE or mid-OVER shall return the block to PLAY.

Structure
REQ-034 The FSM state enum and the BCD digit width constant (4) shall reside in the shared pong package.
REQ-035 A sub-module bcd_counter (parameter DIGITS; inputs inc and clr; saturating; packed BCD output) shall be instantiated once per player.

Verification
REQ-036 Scenario: ball_x=620, ball_width=20, frame_tick -> point_l pulses once, score_l=0x0001, serve_pending=1.
REQ-037 Scenario: ball_x=0 held for 100 frames with SERVE_FRAMES=60 -> score_r increments exactly twice (frames 1 and 62).
REQ-038 Scenario: score_l=0x0009, left point -> score_l=0x0010; score_l=0x9999, left point -> score_l remains 0x9999.
REQ-039 Scenario: WIN_SCORE=11, right player reaches 0x0011 -> game_over=1, winner=1; further exits are ignored; new_game -> both scores 0, state PLAY.
REQ-040 Scenario: ball_x=0 with SCREEN_W ≤ ball_width (both exits true) -> no point pulse; a second scenario asserts reset in the same cycle as frame_tick with an exit -> all outputs return to reset values.
